xorexec_sched: RTL and testbench
================================

// Module: xorexec_sched
// PURPOSE
//  Shares the single xorexec datapath between NREQ requesters. Round-robin arbitrates
//  byte requests into the xorexec input FIFO, keeps in-order origin tags, and routes
//  each result popped from the output FIFO back to the requester that issued it.
//  Sits between requester logic and top_xorexec; enforces that block's input rules.
// PARAMETERS
//  NREQ      4  number of requesters (2..8)
//  DWIDTH    8  data width, matches top_xorexec idata/odata
//  TAG_DEPTH 8  max in-flight pushes (tag FIFO depth, power of 2)
//  MIN_DATA  4  smallest legal request value; smaller values are dropped
// PORTS
//  clk            in   1            clock, all logic on posedge
//  rst_n          in   1            asynchronous reset, active low
//  req_valid      in   NREQ         request i has data
//  req_data       in   NREQ*DWIDTH  request i data in bits [i*DWIDTH +: DWIDTH]
//  req_ready      out  NREQ         request i consumed this cycle (one-hot or 0)
//  rsp_valid      out  NREQ         result for requester i on rsp_data (one-hot or 0)
//  rsp_data       out  DWIDTH       result byte (= odata)
//  rsp_ready      in   NREQ         requester i takes the result
//  ififo_push     out  1            push to xorexec input FIFO
//  idata          out  DWIDTH       pushed data
//  ififo_not_full in   1            input FIFO has space
//  ofifo_pop      out  1            pop xorexec output FIFO
//  ofifo_rdy      in   1            output FIFO has a result
//  odata          in   DWIDTH       output FIFO head
//  err_drop       out  1            1-cycle pulse, cycle after an illegal request is dropped
//  err_orphan     out  1            sticky: ofifo_rdy seen with tag FIFO empty
// BEHAVIOUR
//  - Reset: rr pointer=0, push_q=0, tag FIFO empty, err_drop=0, err_orphan=0;
//    all combinational outputs are then 0. Reset mid-operation drops in-flight tags.
//  - Arbiter: winner w = first i with req_valid[i], scanning from the rr pointer upward
//    with wrap. Selection does not depend on eligibility.
//  - Illegal (req_data[w] < MIN_DATA): req_ready[w]=1, no push; err_drop=1 next cycle.
//  - Legal: eligible = ififo_not_full & !push_q & !tag_full. If eligible, same cycle:
//    req_ready[w]=1, ififo_push=1, idata=req_data[w], tag w written. Otherwise nothing.
//  - push_q <= ififo_push, so a push never occurs in two consecutive cycles.
//  - rr pointer <= (w+1) mod NREQ on any consumed request; it holds otherwise.
//  - Return: head=tag FIFO head. rsp_valid[head] = ofifo_rdy & !tag_empty;
//    rsp_data=odata; ofifo_pop = rsp_valid[head] & rsp_ready[head], which pops the tag.
//    Zero-cycle latency. An unready head requester blocks all returns (in order).
//  - Tag FIFO: push and pop allowed in the same cycle. Push is blocked whenever full,
//    even if a pop occurs that cycle.
//  - ofifo_rdy & tag_empty: no pop; err_orphan set until reset.
//  - ofifo_pop is never asserted unless ofifo_rdy is high.
// CONFIGURATION
//  XSCHED_STATS_EN defined: extra outputs stat_push[15:0], stat_ret[15:0],
//   stat_drop[15:0] count pushes, results returned and dropped requests. They
//   saturate at 16'hFFFF and reset to 0.
//  Undefined: these ports and counters do not exist. No other behaviour changes.
// TESTING
//  1 req_valid=4'b1111, all data 8'h10, not_full=1 -> pushes at cycles 0,2,4,6
//    granted to req 0,1,2,3; ififo_push is never high 2 cycles in a row.
//  2 req1 data 8'h03 -> req_ready[1]=1, no ififo_push, err_drop pulses next cycle,
//    pointer moves to 2.
//  3 Push 8 legal with ofifo_rdy=0 -> 9th is held (req_ready=0) until one result is
//    popped; then it pushes.
//  4 Pushes from req 2,0,3; ofifo returns A,B,C -> rsp_valid 4'b0100 (A),
//    then 4'b0001 (B), then 4'b1000 (C).
//  5 Head req has rsp_ready=0 for 5 cycles -> ofifo_pop=0 for that time,
//    then resumes in order.
//  6 ofifo_rdy=1 after reset with no pushes -> ofifo_pop=0, err_orphan=1 and stays 1.
//    Assert rst_n low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/xorexec_sched_if.sv
// -----------------------------------------------------------------------------
// xorexec_sched_if
// Bundles the requester-side and xorexec-side buses of xorexec_sched.
//   master : requesters + xorexec FIFOs (the environment around the scheduler)
//   slave  : the scheduler itself
// Signals
//   req_valid/req_data/req_ready   requests in (req_data slot i = [i*DWIDTH +: DWIDTH])
//   rsp_valid/rsp_data/rsp_ready   results routed back to requesters
//   ififo_push/idata/ififo_not_full   push side of the xorexec input FIFO
//   ofifo_pop/ofifo_rdy/odata         pop side of the xorexec output FIFO
//
// Handshake semantics (all channels): a transfer happens in a cycle where the
// producer's valid and the consumer's ready are both high at the rising edge.
// req_ready and ofifo_pop are combinational acknowledgements of the same-cycle
// valid (req_valid / ofifo_rdy); valid never depends on the matching ready.
// -----------------------------------------------------------------------------
interface xorexec_sched_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]        rsp_ready;
  logic                   ififo_push;
  logic [DWIDTH-1:0]      idata;
  logic                   ififo_not_full;
  logic                   ofifo_pop;
  logic                   ofifo_rdy;
  logic [DWIDTH-1:0]      odata;

  modport master (
    output req_valid, req_data, rsp_ready, ififo_not_full, ofifo_rdy, odata,
    input  req_ready, rsp_valid, rsp_data, ififo_push, idata, ofifo_pop
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, ififo_not_full, ofifo_rdy, odata,
    output req_ready, rsp_valid, rsp_data, ififo_push, idata, ofifo_pop
  );
endinterface

// File: rtl/xorexec_sched.sv
// -----------------------------------------------------------------------------
// xorexec_sched
// Shares one xorexec datapath between NREQ requesters. A round-robin arbiter
// feeds byte requests into the xorexec input FIFO, an in-order tag FIFO records
// the origin of every push, and each result at the head of the xorexec output
// FIFO is routed back to the requester that issued it.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low
//   bus         xorexec_sched_if.slave (requests, results, xorexec FIFO ports)
//   err_drop    1-cycle pulse the cycle after an illegal request is dropped
//   err_orphan  sticky: a result was offered while no tag was outstanding
//   stat_push/stat_ret/stat_drop  16-bit saturating counters, only present
//               when XSCHED_STATS_EN is defined
//
// Optional feature macro: XSCHED_STATS_EN
// -----------------------------------------------------------------------------
module xorexec_sched #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int TAG_DEPTH = 8,
  parameter int MIN_DATA  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  xorexec_sched_if.slave   bus,
  output logic             err_drop,
  output logic             err_orphan
`ifdef XSCHED_STATS_EN
  ,
  output logic [15:0]      stat_push,
  output logic [15:0]      stat_ret,
  output logic [15:0]      stat_drop
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);

  logic [PW-1:0]     rr_ptr;
  logic              push_q;

  // Tag FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              tag_empty;
  logic              tag_full;
  logic [PW-1:0]     head;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       idx;
  logic [DWIDTH-1:0] win_data;
  logic [NREQ-1:0]   win_oh;
  logic              illegal;
  logic              push;
  logic              drop_now;
  logic              consumed;
  logic              ret_avail;
  logic              pop;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head      = tag_mem[rd_ptr[AW-1:0]];

  // Round-robin winner: first valid requester at or after rr_ptr, with wrap.
  // Gated by rst_n so nothing is acknowledged while reset is held.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    found = found & rst_n;
  end

  assign win_data = bus.req_data[win*DWIDTH +: DWIDTH];
  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign illegal  = (win_data < DWIDTH'(MIN_DATA));

  // Illegal requests are acknowledged and discarded regardless of FIFO state;
  // legal ones wait for input-FIFO space, a free tag slot and a non-push cycle.
  assign drop_now = found & illegal;
  assign push     = found & ~illegal & bus.ififo_not_full & ~push_q & ~tag_full;
  assign consumed = drop_now | push;

  // Result return: the head tag names the only requester that may take it,
  // so a stalled head blocks every later result.
  assign ret_avail = bus.ofifo_rdy & ~tag_empty;
  assign pop       = ret_avail & bus.rsp_ready[head];

  always_comb begin
    bus.req_ready  = consumed ? win_oh : '0;
    bus.ififo_push = push;
    bus.idata      = push ? win_data : '0;
    bus.rsp_valid  = ret_avail ? ({{(NREQ-1){1'b0}}, 1'b1} << head) : '0;
    bus.rsp_data   = rst_n ? bus.odata : '0;
    bus.ofifo_pop  = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      push_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_drop   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      push_q   <= push;
      err_drop <= drop_now;
      if (consumed) rr_ptr <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      if (push)     wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)      rd_ptr <= rd_ptr + (AW+1)'(1);
      if (bus.ofifo_rdy && tag_empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: only slots between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= win;
  end

`ifdef XSCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_push <= '0;
      stat_ret  <= '0;
      stat_drop <= '0;
    end else begin
      if (push && stat_push != 16'hFFFF)     stat_push <= stat_push + 16'd1;
      if (pop && stat_ret != 16'hFFFF)       stat_ret  <= stat_ret + 16'd1;
      if (drop_now && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xorexec_sched.sv
// -----------------------------------------------------------------------------
// tb_xorexec_sched
// Directed scenarios followed by a randomized phase. The bench plays both the
// requesters and a stand-in xorexec whose result for pushed byte b is b ^ 8'h5A.
// The reference model keeps the round-robin pointer as an integer and the
// outstanding origins / results as queues.
// -----------------------------------------------------------------------------
module tb_xorexec_sched;
  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int TD       = 8;
  localparam int MIN_DATA = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic err_drop;
  logic err_orphan;
`ifdef XSCHED_STATS_EN
  logic [15:0] stat_push, stat_ret, stat_drop;
`endif

  xorexec_sched_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  xorexec_sched #(.NREQ(NREQ), .DWIDTH(DW), .TAG_DEPTH(TD), .MIN_DATA(MIN_DATA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_drop   (err_drop),
    .err_orphan (err_orphan)
`ifdef XSCHED_STATS_EN
    ,
    .stat_push  (stat_push),
    .stat_ret   (stat_ret),
    .stat_drop  (stat_drop)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // reference model
  int          m_rr;
  bit          m_push_q;
  bit          m_drop;
  bit          m_orphan;
  int          tag_q[$];
  logic [DW-1:0] exp_q[$];

  // observed snapshot of the last cycle
  logic [NREQ-1:0] o_ready, o_rsp_valid;
  logic            o_push, o_pop, o_drop, o_orphan;
  logic [DW-1:0]   o_idata, o_rsp_data;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_push_q = 0; m_drop = 0; m_orphan = 0;
    tag_q.delete();
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_data = '0; bus.rsp_ready = '0;
    bus.ififo_not_full = 1'b0; bus.ofifo_rdy = 1'b0; bus.odata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},  bus.req_ready, 0);
    chk({tag, "_ififo_push"}, bus.ififo_push, 0);
    chk({tag, "_idata"},      bus.idata, 0);
    chk({tag, "_rsp_valid"},  bus.rsp_valid, 0);
    chk({tag, "_rsp_data"},   bus.rsp_data, 0);
    chk({tag, "_ofifo_pop"},  bus.ofifo_pop, 0);
    chk({tag, "_err_drop"},   err_drop, 0);
    chk({tag, "_err_orphan"}, err_orphan, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus with full model check. ofifo_rdy is only offered when
  // the stand-in xorexec holds a result, unless raw forces it.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d, input bit nf,
                       input bit ordy, input bit raw, input logic [NREQ-1:0] rr);
    int w, head;
    bit found, illegal, push, avail, pop, orphan_now;
    logic [DW-1:0] wd, od;
    logic [NREQ-1:0] e_ready, e_rsp;
    @(negedge clk);
    bus.req_valid = v; bus.req_data = d; bus.ififo_not_full = nf; bus.rsp_ready = rr;
    bus.ofifo_rdy = raw ? ordy : (ordy && exp_q.size() > 0);
    od = (exp_q.size() > 0) ? exp_q[0] : DW'($urandom);
    bus.odata = od;
    #1;
    found = 0; w = 0;
    for (int k = 0; k < NREQ; k++)
      if (!found && v[(m_rr + k) % NREQ]) begin found = 1; w = (m_rr + k) % NREQ; end
    wd      = d[w*DW +: DW];
    illegal = found && (wd < MIN_DATA);
    push    = found && !illegal && nf && !m_push_q && (tag_q.size() < TD);
    e_ready = (illegal || push) ? (NREQ'(1) << w) : '0;
    avail   = bus.ofifo_rdy && (tag_q.size() > 0);
    head    = (tag_q.size() > 0) ? tag_q[0] : 0;
    e_rsp   = avail ? (NREQ'(1) << head) : '0;
    pop     = avail && rr[head];
    orphan_now = bus.ofifo_rdy && (tag_q.size() == 0);

    o_ready = bus.req_ready; o_push = bus.ififo_push; o_idata = bus.idata;
    o_rsp_valid = bus.rsp_valid; o_rsp_data = bus.rsp_data; o_pop = bus.ofifo_pop;
    o_drop = err_drop; o_orphan = err_orphan;

    chk("req_ready", o_ready, e_ready);
    chk("ififo_push", o_push, push);
    if (push) chk("idata", o_idata, wd);
    chk("rsp_valid", o_rsp_valid, e_rsp);
    if (avail) chk("rsp_data", o_rsp_data, od);
    chk("ofifo_pop", o_pop, pop);
    chk("err_drop", o_drop, m_drop);
    chk("err_orphan", o_orphan, m_orphan);

    @(posedge clk);
    if (pop) begin void'(tag_q.pop_front()); void'(exp_q.pop_front()); end
    if (push) begin tag_q.push_back(w); exp_q.push_back(wd ^ 8'h5A); end
    if (illegal || push) m_rr = (w + 1) % NREQ;
    m_push_q = push;
    m_drop   = illegal;
    if (orphan_now) m_orphan = 1;
  endtask

  function automatic logic [NREQ*DW-1:0] rand_data();
    logic [NREQ*DW-1:0] d;
    for (int i = 0; i < NREQ; i++)
      d[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, MIN_DATA-1))
                                                  : DW'($urandom_range(MIN_DATA, 255));
    return d;
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // 1: all requesting, pushes every other cycle in round-robin order
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, {NREQ{8'h10}}, 1, 0, 0, 4'b0000);
      chk("t1_grant", o_ready, (c % 2 == 0) ? (4'b0001 << (c / 2)) : 4'b0000);
      chk("t1_push", o_push, (c % 2 == 0) ? 1 : 0);
    end
    for (int c = 0; c < 6; c++) cycle(4'b0000, '0, 1, 1, 0, 4'b1111);

    // 2: illegal request dropped, pointer advances past it
    do_reset();
    cycle(4'b0010, {8'h10, 8'h10, 8'h03, 8'h10}, 1, 0, 0, 4'b0000);
    chk("t2_ready", o_ready, 4'b0010);
    chk("t2_push", o_push, 0);
    cycle(4'b0000, '0, 1, 0, 0, 4'b0000);
    chk("t2_err_drop", o_drop, 1);
    cycle(4'b0111, {NREQ{8'h10}}, 1, 0, 0, 4'b0000);
    chk("t2_next_grant", o_ready, 4'b0100);
    cycle(4'b0000, '0, 1, 0, 0, 4'b0000);
    chk("t2_drop_cleared", o_drop, 0);

    // 3: eight in flight, ninth held until a pop frees a tag slot
    do_reset();
    for (int c = 0; c < 16; c++) cycle(4'b0001, {NREQ{8'h20}}, 1, 0, 0, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0001, {NREQ{8'h21}}, 1, 0, 0, 4'b0000);
      chk("t3_hold", o_ready, 4'b0000);
    end
    cycle(4'b0001, {NREQ{8'h21}}, 1, 1, 0, 4'b1111);
    chk("t3_pop", o_pop, 1);
    chk("t3_hold_on_pop", o_ready, 4'b0000);
    cycle(4'b0001, {NREQ{8'h21}}, 1, 0, 0, 4'b0000);
    chk("t3_push_after", o_push, 1);
    chk("t3_idata_after", o_idata, 8'h21);

    // 4: results routed back in push order
    do_reset();
    cycle(4'b0100, {8'h43, 8'h42, 8'h41, 8'h40}, 1, 0, 0, 4'b0000);
    cycle(4'b0000, '0, 1, 0, 0, 4'b0000);
    cycle(4'b0001, {8'h43, 8'h42, 8'h41, 8'h40}, 1, 0, 0, 4'b0000);
    cycle(4'b0000, '0, 1, 0, 0, 4'b0000);
    cycle(4'b1000, {8'h43, 8'h42, 8'h41, 8'h40}, 1, 0, 0, 4'b0000);
    cycle(4'b0000, '0, 1, 1, 0, 4'b1111);
    chk("t4_rsp_a", o_rsp_valid, 4'b0100);
    chk("t4_data_a", o_rsp_data, 8'h42 ^ 8'h5A);
    cycle(4'b0000, '0, 1, 1, 0, 4'b1111);
    chk("t4_rsp_b", o_rsp_valid, 4'b0001);
    chk("t4_data_b", o_rsp_data, 8'h40 ^ 8'h5A);
    cycle(4'b0000, '0, 1, 1, 0, 4'b1111);
    chk("t4_rsp_c", o_rsp_valid, 4'b1000);
    chk("t4_data_c", o_rsp_data, 8'h43 ^ 8'h5A);

    // 5: unready head requester blocks all returns
    do_reset();
    cycle(4'b0010, {NREQ{8'h50}}, 1, 0, 0, 4'b0000);
    cycle(4'b0000, '0, 1, 0, 0, 4'b0000);
    cycle(4'b0100, {NREQ{8'h51}}, 1, 0, 0, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0000, '0, 1, 1, 0, 4'b1101);
      chk("t5_blocked_pop", o_pop, 0);
      chk("t5_blocked_rsp", o_rsp_valid, 4'b0010);
    end
    cycle(4'b0000, '0, 1, 1, 0, 4'b1111);
    chk("t5_resume_1", o_rsp_valid, 4'b0010);
    chk("t5_resume_pop", o_pop, 1);
    cycle(4'b0000, '0, 1, 1, 0, 4'b1111);
    chk("t5_resume_2", o_rsp_valid, 4'b0100);

    // 6: orphan result, then asynchronous reset in the middle of a burst
    do_reset();
    cycle(4'b0000, '0, 1, 1, 1, 4'b1111);
    chk("t6_orphan_pop", o_pop, 0);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0000, '0, 1, 0, 0, 4'b1111);
      chk("t6_orphan_sticky", o_orphan, 1);
    end
    for (int c = 0; c < 6; c++) cycle(4'b1111, {NREQ{8'h10}}, 1, 1, 0, 4'b1111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    do_reset();

    // randomized traffic
    for (int c = 0; c < 600; c++)
      cycle(NREQ'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 4) != 0),
            $urandom_range(0, 1) == 1, 0,
            {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
